alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
// - Initiator side of the 16-bit ALU operand/select interface.
// - Queues ALU commands (mode, select, carry, A, B) arriving on a valid/ready port.
// - Drives one command at a time onto the ALU inputs and holds it stable for a settle window.
// - Captures result, carry and compare; returns them in order on a valid/ready response port.
// PARAMETERS
// - WIDTH          16  operand/result width; must match the ALU
// - SETTLE_CYCLES   1  full cycles ALU inputs are held before sampling; >=1
// - FIFO_DEPTH      4  command queue entries; power of two, >=2
// PORTS
// - clk          in   1      single clock; all logic on posedge
// - rst          in   1      synchronous, active-high reset
// - cmd_valid    in   1      command offered
// - cmd_ready    out  1      = !fifo_full && !rst
// - cmd_mode     in   1      ALU mode (1 logic, 0 arithmetic)
// - cmd_select   in   4      ALU function select
// - cmd_carry    in   1      ALU carry_in
// - cmd_a        in   WIDTH  operand A
// - cmd_b        in   WIDTH  operand B
// - alu_in_a     out  WIDTH  registered to ALU in_a
// - alu_in_b     out  WIDTH  registered to ALU in_b
// - alu_select   out  4      registered to ALU select
// - alu_mode     out  1      registered to ALU mode
// - alu_carry_in out  1      registered to ALU carry_in
// - alu_result   in   WIDTH  from ALU alu_out
// - alu_carry    in   1      from ALU carry_out
// - alu_compare  in   1      from ALU compare
// - rsp_valid    out  1      response held
// - rsp_ready    in   1      response consumer ready
// - rsp_data     out  WIDTH  captured alu_result
// - rsp_carry    out  1      captured alu_carry
// - rsp_compare  out  1      captured alu_compare
// - busy         out  1      = (state!=IDLE) || !fifo_empty
// BEHAVIOUR
// - Reset: all outputs 0; FIFO emptied (pointers and count 0); state IDLE; settle counter 0.
//   In-flight or queued commands are discarded; no response for them is ever produced.
// - Queue: push on cmd_valid&&cmd_ready. Pop only in IDLE when non-empty.
//   Simultaneous push and pop is allowed (count unchanged). Pointers wrap modulo FIFO_DEPTH.
// - FSM IDLE: if !empty, pop the head, load alu_* registers, counter=SETTLE_CYCLES, go to DRIVE.
// - FSM DRIVE: decrement the counter each cycle.
//   At the edge where the counter==1: capture alu_result/carry/compare into rsp_*, set rsp_valid,
//   and go to RESPOND.
// - FSM RESPOND: rsp_* held stable while rsp_valid&&!rsp_ready.
//   On handshake: clear rsp_valid and go to IDLE; the next pop occurs no earlier than the next cycle.
// - alu_* outputs change only at a pop; they hold their last values in IDLE and RESPOND (no glitching).
// - Latency: command accepted in cycle T with empty queue and IDLE produces rsp_valid in
//   cycle T+2+SETTLE_CYCLES. Throughput: 1 op per SETTLE_CYCLES+2 cycles with rsp_ready=1.
// - Responses are strictly in command order; the sequencer performs no arithmetic of its own.
// CONFIGURATION
// - ALU_SEQ_CHAIN_EN defined: adds input port cmd_chain (1 bit), stored in the FIFO entry.
//   At pop with chain=1, alu_in_a = last captured rsp_data (0 after reset) instead of cmd_a.
// - ALU_SEQ_CHAIN_EN undefined: cmd_chain port absent; alu_in_a always equals the queued cmd_a.
// TESTING
// - Add: mode=0 sel=9 A=0x0003 B=0x0004, accepted at T, SETTLE=1
//   -> rsp_valid at T+3, rsp_data=0x0007, rsp_compare=0.
// - Xor: mode=1 sel=6 A=0xFF00 B=0x0FF0 -> rsp_data=0xF0F0.
//   Equal: A=B=0x1234 any sel -> rsp_compare=1.
// - Backpressure: rsp_ready=0, 6 back-to-back cmds -> exactly 5 accepted, cmd_ready=0.
//   Release rsp_ready -> 5 responses in order; rsp_* stable while stalled.
// - Reset mid-DRIVE with 3 queued cmds -> next cycle rsp_valid=0, busy=0, cmd_ready=1;
//   no stale responses are produced afterwards.
// - SETTLE_CYCLES=3: alu_in_a/b constant for 3 cycles before capture; rsp_valid at T+5.
// - Chain (ALU_SEQ_CHAIN_EN): ADD 0x0001+0x0001 -> 0x0002;
//   then chain=1 sel=9 B=0x0005 -> rsp_data=0x0007.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and response bundle of the ALU operand sequencer.
// The master modport is the sequencer; slave is the command source, ALU and response sink.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic [3:0]       cmd_select;
    logic             cmd_carry;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
    logic             cmd_chain;
`endif

    logic [WIDTH-1:0] alu_in_a;
    logic [WIDTH-1:0] alu_in_b;
    logic [3:0]       alu_select;
    logic             alu_mode;
    logic             alu_carry_in;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_compare;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;
    logic             rsp_compare;

    modport master (
        input  cmd_valid, cmd_mode, cmd_select, cmd_carry, cmd_a, cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
        input  cmd_chain,
`endif
        output cmd_ready,
        output alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
        input  alu_result, alu_carry, alu_compare,
        output rsp_valid, rsp_data, rsp_carry, rsp_compare,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_select, cmd_carry, cmd_a, cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
        output cmd_chain,
`endif
        input  cmd_ready,
        input  alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
        output alu_result, alu_carry, alu_compare,
        input  rsp_valid, rsp_data, rsp_carry, rsp_compare,
        output rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives one at a time onto the ALU for a settle window and returns results in order.
// Optional ALU_SEQ_CHAIN_EN: cmd_chain substitutes the last captured result for operand A.
module alu_op_sequencer #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_op_sequencer_if.master bus,
    output logic               busy_o
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RESPOND = 2'd2
    } state_e;

    typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
        logic             chain;
`endif
        logic             mode;
        logic [3:0]       select;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    cmd_t              fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    cmd_t              cmd_in;
    cmd_t              head;
    logic              push, pop, full, empty;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  alu_a_q, alu_b_q;
    logic [3:0]        alu_sel_q;
    logic              alu_mode_q, alu_cin_q;
    logic              rsp_valid_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic              rsp_carry_q, rsp_compare_q;
    logic [WIDTH-1:0]  op_a;

    always_comb begin
        cmd_in        = '0;
`ifdef ALU_SEQ_CHAIN_EN
        cmd_in.chain  = bus.cmd_chain;
`endif
        cmd_in.mode   = bus.cmd_mode;
        cmd_in.select = bus.cmd_select;
        cmd_in.carry  = bus.cmd_carry;
        cmd_in.a      = bus.cmd_a;
        cmd_in.b      = bus.cmd_b;
    end

    assign full          = (count_q == FCNT_W'(FIFO_DEPTH));
    assign empty         = (count_q == '0);
    assign bus.cmd_ready = !full && !rst_i;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state_q == IDLE) && !empty;
    assign head          = fifo_q[rd_ptr_q];

    // Queue pointer/occupancy update; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= cmd_in;
    end

`ifdef ALU_SEQ_CHAIN_EN
    assign op_a = head.chain ? rsp_data_q : head.a;
`else
    assign op_a = head.a;
`endif

    // Sequencer: load ALU inputs at pop, hold for the settle window, capture, wait for handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= '0;
            alu_mode_q    <= 1'b0;
            alu_cin_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_compare_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        alu_a_q    <= op_a;
                        alu_b_q    <= head.b;
                        alu_sel_q  <= head.select;
                        alu_mode_q <= head.mode;
                        alu_cin_q  <= head.carry;
                        cnt_q      <= CNT_W'(SETTLE_CYCLES);
                        state_q    <= DRIVE;
                    end
                end
                DRIVE: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_data_q    <= bus.alu_result;
                        rsp_carry_q   <= bus.alu_carry;
                        rsp_compare_q <= bus.alu_compare;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_in_a     = alu_a_q;
    assign bus.alu_in_b     = alu_b_q;
    assign bus.alu_select   = alu_sel_q;
    assign bus.alu_mode     = alu_mode_q;
    assign bus.alu_carry_in = alu_cin_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_carry    = rsp_carry_q;
    assign bus.rsp_compare  = rsp_compare_q;
    assign busy_o           = (state_q != IDLE) || !empty;

endmodule
